// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and sizing helpers for the carry-save accumulator
// Contents: FSM state enum, accumulator/chunk sizing functions, chunk-fit check.
package csa_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } csa_state_e;

    function automatic int acc_width(input int width, input int guard);
        return width + guard;
    endfunction

    function automatic int num_chunks(input int acc_w, input int chunk);
        return acc_w / chunk;
    endfunction

    // The chunked carry-propagate pass needs the accumulator to split evenly.
    function automatic bit chunk_fits(input int acc_w, input int chunk);
        return (chunk > 0) && ((acc_w % chunk) == 0);
    endfunction

endpackage

// File: rtl/csa_compress_3to2.sv
// rtl/csa_compress_3to2.sv - bitwise 3:2 carry-save compressor
// Ports: a, b, c (W-bit addends) -> sum (a^b^c), carry (majority << 1, bit 0 zero).
module csa_compress_3to2 #(
    parameter int W = 72
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    // Carry out of bit i weighs 2^(i+1); the top carry falls off (modulo 2^W).
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - multi-operand carry-save accumulator with chunked final add
// Ports: clk, rst_n (async, active low), clr (frame abort while accumulating),
//        in_valid/in_ready/in_data/in_last (operand stream),
//        out_valid/out_ready/out_sum/out_count (frame result).
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GUARD = 8,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH+GUARD-1:0] out_sum,
    output logic [CNT_W-1:0]       out_count
);

    localparam int ACC_W  = acc_width(WIDTH, GUARD);
    localparam int NCHUNK = num_chunks(ACC_W, CHUNK);
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!chunk_fits(ACC_W, CHUNK)) begin : g_chunk_check
        $error("csa_accumulator: accumulator width must be a multiple of CHUNK");
    end

    csa_state_e       state;
    logic [ACC_W-1:0] s_q;
    logic [ACC_W-1:0] c_q;
    logic [ACC_W-1:0] s_nxt;
    logic [ACC_W-1:0] c_nxt;
    logic [ACC_W-1:0] x_ext;
    logic [KW-1:0]    k_q;
    logic             cy_q;
    logic             accept;
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK-1:0] c_chunk;
    logic [CHUNK:0]   chunk_sum;

    assign in_ready = (state == ST_ACCUM) && !clr;
    assign accept   = in_valid && in_ready;
    assign x_ext    = ACC_W'(in_data);

    csa_compress_3to2 #(
        .W(ACC_W)
    ) u_compress (
        .a     (s_q),
        .b     (c_q),
        .c     (x_ext),
        .sum   (s_nxt),
        .carry (c_nxt)
    );

    // One chunk of the final ripple add per cycle; carry chains between chunks via cy_q.
    assign s_chunk   = s_q[k_q*CHUNK +: CHUNK];
    assign c_chunk   = c_q[k_q*CHUNK +: CHUNK];
    assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            s_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            cy_q      <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (clr) begin
                        s_q       <= '0;
                        c_q       <= '0;
                        out_count <= '0;
                    end else if (accept) begin
                        s_q <= s_nxt;
                        c_q <= c_nxt;
                        if (out_count != {CNT_W{1'b1}}) begin
                            out_count <= out_count + CNT_W'(1);
                        end
                        if (in_last) begin
                            state <= ST_RESOLVE;
                            k_q   <= '0;
                            cy_q  <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    out_sum[k_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    cy_q <= chunk_sum[CHUNK];
                    if (k_q == KW'(NCHUNK - 1)) begin
                        // Final carry out of the top chunk is dropped: result wraps.
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        k_q       <= '0;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        s_q       <= '0;
                        c_q       <= '0;
                        out_count <= '0;
                        state     <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Parametrised multi-operand accumulator built on carry-save arithmetic. Accepts a frame of WIDTH-bit unsigned operands one per cycle over a valid/ready stream.
- Operands are kept in redundant sum/carry form, so no carry ever propagates during accumulation.
- On the last operand, a multi-cycle chunked carry-propagate pass resolves the total, which is presented on a valid/ready output.
- Sits downstream of the combinational 3-operand CSA stage, for dot-product and checksum reduction.

Parameters:
- WIDTH, 64: operand width in bits.
- GUARD, 8: guard bits for growth. Accumulator width ACC_W = WIDTH+GUARD.
- CHUNK, 8: bits resolved per cycle in the CPA pass. ACC_W % CHUNK must be 0. NCHUNK = ACC_W/CHUNK (default 9).
- CNT_W, 16: width of the operand counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous frame abort
- in_valid  in  1  operand valid
- in_ready  out  1  operand accept
- in_data  in  WIDTH  operand, zero-extended to ACC_W
- in_last  in  1  final operand of frame
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_sum  out  ACC_W  frame total modulo 2^ACC_W
- out_count  out  CNT_W  operands accepted in frame

Behaviour:
- Single clock domain: clk. Asynchronous active-low reset: rst_n.
- Reset (asynchronous, any state, including mid-RESOLVE) sets:
  - state = ACCUM
  - S = C = 0, chunk index = 0, chunk carry = 0
  - out_sum = 0, out_count = 0, out_valid = 0
- States: ACCUM, RESOLVE, DONE.
- in_ready = (state==ACCUM) && !clr. Accept = in_valid && in_ready.
- ACCUM, on accept:
  - S <= S ^ C ^ x
  - C <= ((S&C)|(S&x)|(C&x)) << 1, truncated to ACC_W; C[0] is always 0
  - count increments and saturates at 2^CNT_W-1
  - if in_last: go to RESOLVE with chunk index = 0 and chunk carry = 0
  - without accept, S/C/count hold
- RESOLVE, each cycle, for chunk k:
  - {cy, out_sum[k*CHUNK +: CHUNK]} <= S chunk + C chunk + cy
  - k increments
  - after chunk NCHUNK-1: discard the final carry (modulo wrap), go to DONE
- Latency: out_valid rises exactly NCHUNK edges after the edge that accepted the in_last operand (default 9).
- DONE:
  - out_valid = 1; out_sum and out_count are stable while out_ready = 0
  - on out_ready: out_valid <= 0; S, C and count clear; state <= ACCUM
  - the next frame's first operand is accepted no earlier than the following cycle
- out_sum is updated only during RESOLVE and holds its last value otherwise. out_valid is the only output qualifier.
- clr:
  - in ACCUM: S, C and count clear; any concurrent operand is dropped (in_ready is low)
  - in RESOLVE and DONE: clr is ignored; a frame in resolution always completes
- Operands arriving while in_ready = 0 are ignored, with no side effects.
- A single-operand frame (in_last on the first operand) is legal: result = operand.

Decomposition:
- Shared package (csa_pkg) holds:
  - the state enum (ACCUM/RESOLVE/DONE)
  - localparam functions for ACC_W and NCHUNK
  - an elaboration check that ACC_W % CHUNK == 0
- Sub-module csa_compress_3to2 (parameter W): purely combinational bitwise full-adder compressor with sum = a^b^c and carry = maj(a,b,c) << 1. It is instantiated once for the accumulate step.
- The FSM, chunked CPA, and counter stay in the top module.

Test Plan:
- Operands 1, 2, 3 (last on 3), out_ready = 1 → out_valid exactly 9 cycles after the last accept, out_sum = 6, out_count = 3.
- Operands 0xFFFF_FFFF_FFFF_FFFF then 1 (last) → out_sum = 0x01_0000_0000_0000_0000. This exercises the carry ripple across all 9 chunks.
- 256 operands of 0xFFFF_FFFF_FFFF_FFFF → out_sum = 0xFF_FFFF_FFFF_FFFF_FF00, out_count = 256. A further frame of 257 such operands + 0x100 wraps to out_sum = 0xFFFF_FFFF_FFFF_FFFF.
- Result present, out_ready held 0 for 5 cycles while in_valid = 1 with data 7 → out_sum/out_count stable, in_ready = 0. After the accept, the next frame of 5 (last) → out_sum = 5, out_count = 1.
- Operands 10, 20, then clr together with in_valid (data 99), then 5 (last) → out_sum = 5, out_count = 1. The 99 is not counted.
- rst_n pulsed low during RESOLVE chunk 4 → out_valid = 0 immediately. After release: in_ready = 1, out_sum = 0, and the next frame 3+4 → 7.
